// File: rtl/and_stim_check.sv
// Self-checking stimulus source and response checker for a registered 8-bit AND gate.
// Two Galois LFSRs drive operand pairs; the gate output is checked two edges after each issue.
module and_stim_check #(
   parameter int               WIDTH       = 8,
   parameter int               NUM_VECTORS = 16,
   parameter logic [WIDTH-1:0] SEED_A      = WIDTH'(29),
   parameter logic [WIDTH-1:0] SEED_B      = WIDTH'(95),
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   input  logic [WIDTH-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx,
   output logic [WIDTH-1:0] first_err_exp,
   output logic [WIDTH-1:0] first_err_got
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_a, lfsr_b;
   logic [WIDTH-1:0] a_nxt, b_nxt;
   logic [15:0]      cnt_q;
   logic [WIDTH-1:0] exp1, exp2;
   logic             v1, v2;
   logic [15:0]      idx1, idx2;
   logic             load, issue, finish;
   logic             mismatch;
   logic [15:0]      err_next;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
      return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
   endfunction

   assign a_nxt = lfsr_step(lfsr_a);
   assign b_nxt = lfsr_step(lfsr_b);

   // X/Z on the gate output must count as a mismatch, hence the case inequality.
   assign mismatch = v2 && (dut_out !== exp2);
   assign err_next = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      issue   = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (cnt_q == LAST_IDX) state_d = DRAIN;
            else                   issue   = 1'b1;
         end
         DRAIN: begin
            state_d = DONE;
            finish  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         lfsr_a        <= SEED_A;
         lfsr_b        <= SEED_B;
         a_out         <= '0;
         b_out         <= '0;
         cnt_q         <= '0;
         exp1          <= '0;
         exp2          <= '0;
         v1            <= 1'b0;
         v2            <= 1'b0;
         idx1          <= '0;
         idx2          <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_exp <= '0;
         first_err_got <= '0;
         pass          <= 1'b0;
      end else begin
         state_q <= state_d;
         exp2    <= exp1;
         v2      <= v1;
         idx2    <= idx1;

         if (load) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
            a_out  <= SEED_A;
            b_out  <= SEED_B;
            cnt_q  <= '0;
            exp1   <= SEED_A & SEED_B;
            v1     <= 1'b1;
            idx1   <= '0;
         end else if (issue) begin
            lfsr_a <= a_nxt;
            lfsr_b <= b_nxt;
            a_out  <= a_nxt;
            b_out  <= b_nxt;
            cnt_q  <= cnt_q + 16'd1;
            exp1   <= a_nxt & b_nxt;
            v1     <= 1'b1;
            idx1   <= cnt_q + 16'd1;
         end else begin
            v1 <= 1'b0;
         end

         if (load) begin
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            pass          <= 1'b0;
         end else begin
            err_count <= err_next;
            if (mismatch && err_count == 16'd0) begin
               first_err_idx <= idx2;
               first_err_exp <= exp2;
               first_err_got <= dut_out;
            end
            if (finish) pass <= (err_next == 16'd0);
         end
      end
   end

   assign busy = (state_q == RUN) || (state_q == DRAIN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_and_stim_check.sv
// Bench for and_stim_check: attaches ideal and faulty gate models and checks run results
// against an arithmetic LFSR/fault model.
module tb_and_stim_check;

   localparam int NV = 16;
   localparam int NS = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Main checker (16 vectors) with a configurable faulty gate.
   logic       start = 1'b0;
   logic [7:0] a_out, b_out, dut_out, first_err_exp, first_err_got;
   logic       busy, done, pass;
   logic [15:0] err_count, first_err_idx;
   logic [7:0] g1 = '0, g2 = '0;
   logic [7:0] gmask = '0;
   logic       gval = 1'b0, glat = 1'b0;

   always @(posedge clk) begin
      g1 <= a_out & b_out;
      g2 <= g1;
   end
   always_comb begin
      dut_out = glat ? g2 : ((g1 & ~gmask) | (gval ? gmask : 8'h00));
   end

   and_stim_check u_dut (
      .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
   );

   // Single-vector checker with an ideal gate.
   logic       start1 = 1'b0;
   logic [7:0] a1, b1, o1, fe1, fg1;
   logic       busy1, done1, pass1;
   logic [15:0] ec1, fi1;
   always @(posedge clk) o1 <= a1 & b1;

   and_stim_check #(.NUM_VECTORS(1)) u_one (
      .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .dut_out(o1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
      .first_err_idx(fi1), .first_err_exp(fe1), .first_err_got(fg1)
   );

   // Maximum-length checker with an always-wrong gate.
   logic       start_s = 1'b0;
   logic [7:0] as, bs, os, fes, fgs, gs = '0;
   logic       busy_s, done_s, pass_s;
   logic [15:0] ecs, fis;
   always @(posedge clk) gs <= as & bs;
   assign os = ~gs;

   and_stim_check #(.NUM_VECTORS(NS)) u_sat (
      .clk(clk), .rst(rst), .start(start_s), .a_out(as), .b_out(bs), .dut_out(os),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(ecs),
      .first_err_idx(fis), .first_err_exp(fes), .first_err_got(fgs)
   );

   // Reference model state.
   logic [7:0] ma [NV];
   logic [7:0] mb [NV];
   int         exp_err, exp_fidx;
   logic [7:0] exp_fexp, exp_fgot;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] lstep(input logic [7:0] x);
      int v;
      v = int'(x);
      if (v % 2 == 1) return 8'((v / 2) ^ 184);
      return 8'(v / 2);
   endfunction

   // Gate output for vector i: stuck bits, or the previous vector's AND for the slow gate
   // (the operands are zero before the first vector since runs with it start from reset).
   task automatic build_model(input logic [7:0] mask, input logic val, input logic lat);
      logic [7:0] e, got, prev;
      ma[0] = 8'd29;
      mb[0] = 8'd95;
      for (int i = 1; i < NV; i++) begin
         ma[i] = lstep(ma[i-1]);
         mb[i] = lstep(mb[i-1]);
      end
      exp_err = 0; exp_fidx = 0; exp_fexp = '0; exp_fgot = '0;
      prev = 8'h00;
      for (int i = 0; i < NV; i++) begin
         e   = ma[i] & mb[i];
         got = lat ? prev : ((e & ~mask) | (val ? mask : 8'h00));
         if (got !== e) begin
            if (exp_err == 0) begin
               exp_fidx = i; exp_fexp = e; exp_fgot = got;
            end
            exp_err++;
         end
         prev = e;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_cleared(input string name);
      checks++;
      if (a_out !== 8'd0 || b_out !== 8'd0 || err_count !== 16'd0 || first_err_idx !== 16'd0 ||
          first_err_exp !== 8'd0 || first_err_got !== 8'd0 || busy !== 1'b0 || done !== 1'b0 ||
          pass !== 1'b0) begin
         errors++;
         $display("FAIL %s: a=%h b=%h err=%h fidx=%h fexp=%h fgot=%h busy=%b done=%b pass=%b, want all zero",
                  name, a_out, b_out, err_count, first_err_idx, first_err_exp, first_err_got, busy, done, pass);
      end
   endtask

   // One complete run of the main checker; sp1/sp2 are edge offsets where start is re-pulsed.
   task automatic do_run(input logic [7:0] mask, input logic val, input logic lat,
                         input int sp1, input int sp2, input string name);
      int de;
      gmask = mask; gval = val; glat = lat;
      build_model(mask, val, lat);
      repeat ($urandom_range(3, 0)) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (a_out !== ma[0] || b_out !== mb[0]) begin
         errors++;
         $display("FAIL %s first_issue: a=%0d b=%0d, want %0d %0d", name, a_out, b_out, ma[0], mb[0]);
      end
      checks++;
      if (err_count !== 16'd0 || done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
         errors++;
         $display("FAIL %s start_edge: err=%0d done=%b busy=%b pass=%b, want 0 0 1 0",
                  name, err_count, done, busy, pass);
      end
      de = 0;
      for (int k = 1; k <= 40 && de == 0; k++) begin
         start = (k == sp1) || (k == sp2);
         tick();
         start = 1'b0;
         if (k < NV) begin
            checks++;
            if (a_out !== ma[k] || b_out !== mb[k]) begin
               errors++;
               $display("FAIL %s issue%0d: a=%h b=%h, want %h %h", name, k, a_out, b_out, ma[k], mb[k]);
            end
         end
         checks++;
         if (busy !== (k <= NV)) begin
            errors++;
            $display("FAIL %s busy@%0d: got %b want %b", name, k, busy, (k <= NV));
         end
         if (done === 1'b1) de = k;
      end
      checks++;
      if (de != NV + 1) begin
         errors++;
         $display("FAIL %s done_edge: got s+%0d want s+%0d", name, de, NV + 1);
      end
      checks++;
      if (err_count !== 16'(exp_err) || pass !== (exp_err == 0)) begin
         errors++;
         $display("FAIL %s result: err=%0d pass=%b, want err=%0d pass=%b",
                  name, err_count, pass, exp_err, (exp_err == 0));
      end
      if (exp_err > 0) begin
         checks++;
         if (first_err_idx !== 16'(exp_fidx) || first_err_exp !== exp_fexp || first_err_got !== exp_fgot) begin
            errors++;
            $display("FAIL %s first_err: idx=%0d exp=%h got=%h, want idx=%0d exp=%h got=%h",
                     name, first_err_idx, first_err_exp, first_err_got, exp_fidx, exp_fexp, exp_fgot);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_cleared("reset");
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || busy_s !== 1'b0 || ecs !== 16'd0) begin
         errors++;
         $display("FAIL reset_others: busy1=%b done1=%b busy_s=%b ecs=%0d, want 0", busy1, done1, busy_s, ecs);
      end
   endtask

   task automatic test_ideal();
      do_run(8'h00, 1'b0, 1'b0, 0, 0, "ideal");
   endtask

   task automatic test_stuck_bit7();
      do_run(8'h80, 1'b1, 1'b0, 0, 0, "stuck7");
   endtask

   task automatic test_random_stuck();
      for (int r = 0; r < 4; r++) begin
         logic [7:0] m;
         m = 8'(1 << $urandom_range(7, 0));
         do_run(m, 1'($urandom_range(1, 0)), 1'b0, 0, 0, "rand_stuck");
      end
   endtask

   task automatic test_latency();
      do_reset();
      do_run(8'h00, 1'b0, 1'b1, 0, 0, "latency2");
   endtask

   task automatic test_mid_reset();
      gmask = 8'hFF; gval = 1'b1; glat = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_cleared("mid_reset");
      do_run(8'h00, 1'b0, 1'b0, 0, 0, "after_reset");
   endtask

   task automatic test_start_ignored();
      do_run(8'h00, 1'b0, 1'b0, $urandom_range(NV, 1), NV + 1, "start_ignored");
   endtask

   task automatic test_restart_from_done();
      do_run(8'h00, 1'b1, 1'b0, 0, 0, "pre_restart");
      do_run(8'h01, 1'b1, 1'b0, 0, 0, "restart_faulty");
      do_run(8'h00, 1'b0, 1'b0, 0, 0, "restart_ideal");
   endtask

   task automatic test_one_vector();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      checks++;
      if (a1 !== 8'd29 || b1 !== 8'd95 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL one_issue: a=%0d b=%0d busy=%b, want 29 95 1", a1, b1, busy1);
      end
      tick();
      checks++;
      if (done1 !== 1'b0 || a1 !== 8'd29 || b1 !== 8'd95) begin
         errors++;
         $display("FAIL one_s1: done=%b a=%0d b=%0d, want 0 29 95", done1, a1, b1);
      end
      tick();
      checks++;
      if (done1 !== 1'b1 || pass1 !== 1'b1 || ec1 !== 16'd0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL one_done: done=%b pass=%b err=%0d busy=%b, want 1 1 0 0", done1, pass1, ec1, busy1);
      end
   endtask

   task automatic test_saturation();
      int de;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      de = 0;
      for (int k = 1; k <= NS + 20 && de == 0; k++) begin
         tick();
         if (done_s === 1'b1) de = k;
      end
      checks++;
      if (de != NS + 1) begin
         errors++;
         $display("FAIL sat_done_edge: got s+%0d want s+%0d", de, NS + 1);
      end
      checks++;
      if (ecs !== 16'hFFFF || pass_s !== 1'b0) begin
         errors++;
         $display("FAIL sat_count: err=%h pass=%b, want ffff 0", ecs, pass_s);
      end
      checks++;
      if (fis !== 16'd0 || fes !== 8'd29 || fgs !== 8'(~8'd29)) begin
         errors++;
         $display("FAIL sat_first: idx=%0d exp=%h got=%h, want 0 1d e2", fis, fes, fgs);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck_bit7();
      test_random_stuck();
      test_latency();
      test_mid_reset();
      test_start_ignored();
      test_restart_from_done();
      test_one_vector();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/and_stim_check.md
Name: and_stim_check

Overview:
- Self-checking stimulus source and response checker for the 8-bit registered AND gate (one-clock-latency `in1 & in2` → `out`).
- Drives operand pairs from two LFSRs into the gate's inputs and samples the gate's registered output two edges after each issue.
- Compares each sample against an internally pipelined expected value and reports pass/fail, an error count and the first mismatch.
- Replaces hand-written `initial`-block stimulus in simulation top levels. Fully synthesizable for on-board self-test.

Parameters:
- WIDTH, 8, operand/result width.
- NUM_VECTORS, 16, vectors per run; legal range 1..65535.
- SEED_A, 8'd29, LFSR A seed; also the first operand A issued.
- SEED_B, 8'd95, LFSR B seed; also the first operand B issued.
- TAPS, 8'hB8, Galois LFSR feedback mask shared by both LFSRs.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- a_out  output  WIDTH  operand to gate `in1`, registered.
- b_out  output  WIDTH  operand to gate `in2`, registered.
- dut_out  input  WIDTH  gate `out`.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  16  mismatches this run; saturates at 16'hFFFF.
- first_err_idx  output  16  vector index of the first mismatch.
- first_err_exp  output  WIDTH  expected value at the first mismatch.
- first_err_got  output  WIDTH  dut_out value at the first mismatch.

Behaviour:
- Reset (rst high at posedge) forces:
  - state IDLE.
  - a_out, b_out, err_count, first_err_* = 0.
  - busy, done, pass = 0.
  - LFSRs = seeds; expected pipeline and valid bits cleared.
  - rst has priority over every other input and applies mid-run; no partial results survive.
- States:
  - IDLE: wait for start.
  - RUN: issue vectors.
  - DRAIN: 2 cycles, final compares only.
  - DONE: hold results.
- IDLE/DONE → RUN on the posedge where start=1. That same edge:
  - loads a_out=SEED_A, b_out=SEED_B (vector 0).
  - clears err_count, first_err_*, pass, done.
  - reloads both LFSRs from the seeds.
- RUN, per posedge:
  - issue vector i: a_out/b_out take the next LFSR states.
  - Galois step: lsb=1 → (x>>1)^TAPS, else x>>1.
  - After NUM_VECTORS issues (edges s..s+N−1), go to DRAIN; a_out/b_out hold the last vector.
- Expected pipeline:
  - On the issue edge, exp1 = next a_out & next b_out, and v1 = 1.
  - Next edge: exp2 = exp1, v2 = v1.
  - On the following edge, if v2 is set, compare dut_out against exp2.
  - Vector issued at edge k is therefore checked at edge k+2.
- Mismatch handling:
  - err_count increments, saturating.
  - On the first mismatch of the run, capture first_err_idx, first_err_exp and first_err_got.
- DRAIN:
  - Lasts 2 edges. The second edge (s+N+1) performs the last compare.
  - That edge enters DONE with pass = (err_count after this compare == 0) and done=1.
- DONE: outputs are held. start begins a new run; start in RUN or DRAIN is ignored.
- busy=1 from edge s through edge s+N, i.e. until the DONE entry edge.
- NUM_VECTORS=1: one RUN cycle, DRAIN 2, done after edge s+2.
- dut_out X/Z: treated as a mismatch; compare with !==.

Test Plan:
- Reset, then start for one cycle, with an ideal registered-AND gate attached:
  - first issue is a_out=29, b_out=95; first compare expects 29.
  - done rises after edge s+17; pass=1, err_count=0.
- Gate bit 7 stuck-at-1:
  - err_count equals the number of vectors whose expected bit 7=0.
  - first_err_* matches the first such vector; pass=0.
- Gate with 2-cycle latency (wrong timing):
  - err_count>0; first_err_idx is the first index whose expected value differs from the previous vector's.
- rst asserted at RUN vector 5, then start again:
  - all outputs return to 0 the edge after rst.
  - the new run replays from the seeds and passes with the ideal gate.
- start pulsed during RUN and DRAIN:
  - ignored; done still at s+17.
  - start in DONE restarts and clears err_count.
- NUM_VECTORS=1:
  - one issue of 29/95; done after edge s+2; pass=1.
- err_count saturation (NUM_VECTORS=65535, gate output forced to ~expected):
  - err_count=16'hFFFF; no wrap.
